// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, FSM state encoding and parity helper.
// Used by both the receive and the transmit paths.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10416;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP   = STOP,
    S_BREAK  = BREAK
  } uart_state_t;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx pad.
// Resets to 1 so a reset never looks like a start bit.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rxs
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw line through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], rx};
    end
  end

  assign rxs = sync_r[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, one-cycle valid/frame_err strobes.
// Define UART_RX_PARITY_EN to insert an even-parity bit and enable parity_err.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 parity_err
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic                 rxs;
  uart_state_t          state_r;
  logic [CNT_W-1:0]     clk_cnt_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shreg_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 frame_err_r;
  logic                 busy_r;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_r;
  logic                 parity_err_r;
`endif

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .rxs (rxs)
  );

  // Frame FSM plus datapath; strobes default low so each lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      clk_cnt_r    <= CNT_ZERO;
      bit_idx_r    <= 3'd0;
      shreg_r      <= 8'h00;
      data_r       <= 8'h00;
      valid_r      <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (state_r)
        S_IDLE: begin
          if (!rxs) begin
            state_r   <= S_START;
            clk_cnt_r <= CNT_ZERO;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        S_START: begin
          if (clk_cnt_r == HALF_LAST) begin
            clk_cnt_r <= CNT_ZERO;
            if (!rxs) begin
              state_r   <= S_DATA;
              bit_idx_r <= 3'd0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        S_DATA: begin
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r          <= CNT_ZERO;
            shreg_r[bit_idx_r] <= rxs;
            if (bit_idx_r == 3'd7) begin
              bit_idx_r <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state_r   <= S_PARITY;
`else
              state_r   <= S_STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r <= CNT_ZERO;
            par_bit_r <= rxs;
            state_r   <= S_STOP;
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r <= CNT_ZERO;
            if (rxs) begin
              // Returning to IDLE here lets a start edge right after the midpoint be caught.
              data_r  <= shreg_r;
              valid_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_r <= (par_bit_r != even_parity(shreg_r));
`endif
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= S_BREAK;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        S_BREAK: begin
          if (rxs) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= S_BREAK;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          clk_cnt_r <= CNT_ZERO;
          bit_idx_r <= 3'd0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at CLKS_PER_BIT=16, SYNC_STAGES=2.
// Honours UART_RX_PARITY_EN by sending an extra parity bit per frame.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic       parity_err;

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int valid_cyc = 0;
  int start_cyc = 0;
  logic busy_at_valid = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] exp_d;
  logic exp_p;
  logic [7:0] sb_data[$];
  logic sb_perr[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every valid strobe.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      valid_cyc = cyc;
      busy_at_valid = busy;
      if (sb_data.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_valid: got data %h, required no strobe", data);
      end else begin
        exp_d = sb_data.pop_front();
        exp_p = sb_perr.pop_front();
        tests++;
        if (data !== exp_d) begin
          fails++;
          $display("FAIL sb_data: got %h, required %h", data, exp_d);
        end
        tests++;
        if (parity_err !== exp_p) begin
          fails++;
          $display("FAIL sb_parity_err: got %b, required %b", parity_err, exp_p);
        end
      end
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if (valid || frame_err) begin
      tests++;
      if (valid && frame_err) begin
        fails++;
        $display("FAIL strobe_overlap: valid=%b frame_err=%b, required not both", valid, frame_err);
      end
    end
    if ((valid && prev_valid) || (frame_err && prev_ferr)) begin
      tests++; fails++;
      $display("FAIL strobe_width: valid/frame_err high 2 cycles, required 1");
    end
    prev_valid = valid;
    prev_ferr  = frame_err;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit,
                           input logic par_bit, input logic expect_out);
    if (expect_out) begin
      sb_data.push_back(d);
`ifdef UART_RX_PARITY_EN
      sb_perr.push_back(par_bit != (^d));
`else
      sb_perr.push_back(1'b0);
`endif
    end
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((sb_data.size() != 0 || busy) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    tests++;
    if (k >= budget) begin
      fails++;
      $display("FAIL wait_idle: timeout after %0d clks, pending=%0d busy=%b", k, sb_data.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({data, valid, frame_err, busy, parity_err} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b b=%b pe=%b, required all 0",
               data, valid, frame_err, busy, parity_err);
    end
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_good_frame();
    int nv, nf, lat;
    nv = n_valid; nf = n_ferr;
    send_byte(8'hA5, 1'b1, ^(8'hA5), 1'b1);
    wait_idle(4 * CPB);
    lat = valid_cyc - start_cyc;
    tests++;
    if (n_valid !== nv + 1) begin fails++; $display("FAIL good_valid_count: got %0d, required %0d", n_valid - nv, 1); end
    tests++;
    if (n_ferr !== nf) begin fails++; $display("FAIL good_frame_err: got %0d, required 0", n_ferr - nf); end
    tests++;
    if (data !== 8'hA5) begin fails++; $display("FAIL good_data_hold: got %h, required a5", data); end
    tests++;
    if (lat < 154 || lat > 156) begin fails++; $display("FAIL good_latency: got %0d, required 155", lat); end
    tests++;
    if (busy_at_valid !== 1'b0) begin fails++; $display("FAIL good_busy_at_valid: got %b, required 0", busy_at_valid); end
  endtask

  task automatic test_back_to_back();
    int nv;
    nv = n_valid;
    send_byte(8'h00, 1'b1, 1'b0, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b0, 1'b1);
    wait_idle(4 * CPB);
    tests++;
    if (n_valid !== nv + 2) begin fails++; $display("FAIL b2b_valid_count: got %0d, required 2", n_valid - nv); end
    tests++;
    if (data !== 8'hFF) begin fails++; $display("FAIL b2b_last_data: got %h, required ff", data); end
  endtask

  task automatic test_false_start();
    int nv, nf, bc;
    nv = n_valid; nf = n_ferr; bc = 0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    @(posedge clk); #1;
    tests++;
    if (bc < 6 || bc > 10) begin fails++; $display("FAIL glitch_busy_len: got %0d, required about 8", bc); end
    tests++;
    if (n_valid !== nv || n_ferr !== nf) begin
      fails++;
      $display("FAIL glitch_strobes: got valid=%0d ferr=%0d, required 0 0", n_valid - nv, n_ferr - nf);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: got busy %b, required 0", busy); end
  endtask

  task automatic test_frame_error();
    int nv, nf;
    send_byte(8'hA5, 1'b1, ^(8'hA5), 1'b1);
    wait_idle(4 * CPB);
    nv = n_valid; nf = n_ferr;
    send_byte(8'h3C, 1'b0, ^(8'h3C), 1'b0);
    repeat (40) @(posedge clk);
    #1;
    tests++;
    if (n_ferr !== nf + 1) begin fails++; $display("FAIL ferr_count: got %0d, required 1", n_ferr - nf); end
    tests++;
    if (n_valid !== nv) begin fails++; $display("FAIL ferr_no_valid: got %0d, required 0", n_valid - nv); end
    tests++;
    if (data !== 8'hA5) begin fails++; $display("FAIL ferr_data_kept: got %h, required a5", data); end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL ferr_break_busy: got %b, required 1", busy); end
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL ferr_break_exit: got busy %b, required 0", busy); end
    send_byte(8'h55, 1'b1, ^(8'h55), 1'b1);
    wait_idle(4 * CPB);
    tests++;
    if (n_valid !== nv + 1 || n_ferr !== nf + 1) begin
      fails++;
      $display("FAIL ferr_recover: got valid=%0d ferr=%0d, required 1 1", n_valid - nv, n_ferr - nf);
    end
    tests++;
    if (data !== 8'h55) begin fails++; $display("FAIL ferr_recover_data: got %h, required 55", data); end
  endtask

  task automatic test_reset_mid_frame();
    int nv, nf;
    nv = n_valid; nf = n_ferr;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({data, valid, frame_err, busy} !== 11'h000) begin
      fails++;
      $display("FAIL rst_mid_outputs: got data=%h v=%b fe=%b b=%b, required all 0", data, valid, frame_err, busy);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    #1;
    tests++;
    if (n_valid !== nv || n_ferr !== nf || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_abort: got valid=%0d ferr=%0d busy=%b, required 0 0 0", n_valid - nv, n_ferr - nf, busy);
    end
    send_byte(8'h42, 1'b1, ^(8'h42), 1'b1);
    wait_idle(4 * CPB);
    tests++;
    if (n_valid !== nv + 1 || data !== 8'h42) begin
      fails++;
      $display("FAIL rst_mid_next: got valid=%0d data=%h, required 1 42", n_valid - nv, data);
    end
  endtask

  task automatic test_parity();
    int nv, np;
    nv = n_valid; np = n_perr;
    send_byte(8'h07, 1'b1, 1'b0, 1'b1);
    send_byte(8'h07, 1'b1, 1'b1, 1'b1);
    wait_idle(4 * CPB);
    tests++;
    if (n_valid !== nv + 2) begin fails++; $display("FAIL parity_valid_count: got %0d, required 2", n_valid - nv); end
`ifdef UART_RX_PARITY_EN
    tests++;
    if (n_perr !== np + 1) begin fails++; $display("FAIL parity_err_count: got %0d, required 1", n_perr - np); end
`else
    tests++;
    if (n_perr !== np) begin fails++; $display("FAIL parity_err_tied: got %0d, required 0", n_perr - np); end
`endif
    tests++;
    if (data !== 8'h07) begin fails++; $display("FAIL parity_data: got %h, required 07", data); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_reset_mid_frame();
    test_parity();
    repeat (4 * CPB) @(posedge clk);
    #1;
    tests++;
    if (sb_data.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb_data.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
